// File: rtl/lab2_proc_fetch_resp_queue_pkg.sv
// Shared types and constants for the fetch response queue.
// Holds the buffered instruction entry format, the idle instruction
// word and the drain FSM state encoding.
package lab2_proc_FetchPkg;

  // One buffered instruction together with the PC that fetched it
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instruction word presented whenever no instruction is valid
  localparam logic [31:0] c_fetch_reset_inst = 32'h00000000;

  // Width of every occupancy counter (capacity is at most 8)
  localparam int c_cnt_w = 4;

  // RUN: responses are kept; DRAIN: responses from before a squash are discarded
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/lab2_proc_fetch_resp_queue_ring.sv
// Parameterised circular buffer with synchronous flush.
// A flush empties the ring; a push in the same cycle becomes the sole
// entry afterwards, so post-redirect data survives the flush.
module lab2_proc_FetchRing
  import lab2_proc_FetchPkg::*;
#(
  parameter int p_depth = 2,
  parameter int p_width = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [p_width-1:0] i_pushData,
  input  logic               i_pop,
  output logic [p_width-1:0] o_headData,
  output logic               o_empty,
  output logic [c_cnt_w-1:0] o_count
);

  localparam int c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int c_slots = 1 << c_ptr_w;

  logic [p_width-1:0] r_mem [c_slots];
  logic [c_ptr_w-1:0] r_rdPtr;
  logic [c_ptr_w-1:0] r_wrPtr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] w_wrSlot;

  // Advance a pointer, wrapping at the configured depth rather than at a power of two
  function automatic logic [c_ptr_w-1:0] nextPtr(input logic [c_ptr_w-1:0] ptr);
    if (ptr == c_ptr_w'(p_depth - 1)) begin
      return '0;
    end
    return ptr + c_ptr_w'(1);
  endfunction

  assign w_wrSlot   = i_flush ? '0 : r_wrPtr;
  assign o_headData = r_mem[r_rdPtr];
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

  // Pointer and occupancy tracking; flush restarts both pointers at slot 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= i_push ? nextPtr('0) : '0;
      r_count <= i_push ? c_cnt_w'(1) : '0;
    end else begin
      if (i_push) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (i_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      r_count <= r_count + c_cnt_w'(i_push) - c_cnt_w'(i_pop);
    end
  end

  // Storage write; a push during a flush lands in slot 0 to match the reset pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_slots; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[w_wrSlot] <= i_pushData;
    end
  end

endmodule

// File: rtl/lab2_proc_fetch_resp_queue.sv
// Fetch response queue between the F-stage imem port and the D stage.
// Pairs each imem response with its request PC, buffers instructions the
// D stage cannot take yet, and discards responses belonging to fetches
// that a squash has made stale.
// Optional feature: define LAB2_PROC_FETCH_STATS_EN to add the 16-bit
// saturating squash_drops counter of discarded responses.
module lab2_proc_fetch_resp_queue
  import lab2_proc_FetchPkg::*;
#(
  parameter int          p_entries  = 2,
  parameter logic [31:0] p_reset_pc = 32'h200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ireq_val,
  output logic         ireq_rdy,
  input  logic [31:0]  ireq_pc,
  input  logic         imem_resp_val,
  output logic         imem_resp_rdy,
  input  logic [31:0]  imem_resp_data,
  input  logic         squash,
  output logic         inst_val,
  input  logic         inst_rdy,
  output logic [31:0]  inst_data,
  output logic [31:0]  inst_pc,
`ifdef LAB2_PROC_FETCH_STATS_EN
  output logic [15:0]  squash_drops,
`endif
  output logic [3:0]   num_inflight
);

  fetch_state_t       r_state;
  fetch_state_t       w_stateNext;
  logic [c_cnt_w-1:0] r_inflight;
  logic [c_cnt_w-1:0] w_inflightNext;
  logic [c_cnt_w-1:0] r_dropCnt;
  logic [c_cnt_w-1:0] w_dropNext;

  logic               w_fire;
  logic               w_respCounted;
  logic               w_protoErr;
  logic               w_keep;
  logic               w_drop;
  logic [5:0]         w_occupancy;

  logic               w_bufPush;
  logic               w_bufPop;
  logic               w_bufEmpty;
  logic [c_cnt_w-1:0] w_bufCount;
  fetch_entry_t       w_bufHead;
  fetch_entry_t       w_bufPushData;

  logic [31:0]        w_pcHead;
  logic               w_pcEmpty;
  logic [c_cnt_w-1:0] w_pcCount;

  assign w_fire        = ireq_val & ireq_rdy;
  assign imem_resp_rdy = 1'b1;
  assign num_inflight  = r_inflight;

  // Stale responses still owed count against capacity, so a kept response always finds room
  assign w_occupancy = {2'b00, r_inflight} + {2'b00, w_bufCount} + {2'b00, r_dropCnt};
  assign ireq_rdy    = (w_occupancy < 6'(p_entries));

  assign w_respCounted = imem_resp_val && (r_inflight != '0);
  assign w_protoErr    = imem_resp_val && (r_inflight == '0) && (r_dropCnt == '0);
  assign w_keep        = imem_resp_val && !squash && (r_state == RUN) && !w_protoErr;
  assign w_drop        = imem_resp_val && !w_protoErr && (squash || (r_state == DRAIN));

  // A bypassed response only needs storing when D does not take it this cycle
  assign w_bufPush     = w_keep && !(w_bufEmpty && inst_rdy);
  assign w_bufPop      = !squash && !w_bufEmpty && inst_rdy;
  assign w_bufPushData = '{pc: w_pcHead, inst: imem_resp_data};

  lab2_proc_FetchRing #(
    .p_depth (p_entries),
    .p_width ($bits(fetch_entry_t))
  ) u_instBuf (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (squash),
    .i_push     (w_bufPush),
    .i_pushData (w_bufPushData),
    .i_pop      (w_bufPop),
    .o_headData (w_bufHead),
    .o_empty    (w_bufEmpty),
    .o_count    (w_bufCount)
  );

  lab2_proc_FetchRing #(
    .p_depth (p_entries),
    .p_width (32)
  ) u_pcFifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (squash),
    .i_push     (w_fire),
    .i_pushData (ireq_pc),
    .i_pop      (w_keep),
    .o_headData (w_pcHead),
    .o_empty    (w_pcEmpty),
    .o_count    (w_pcCount)
  );

  // Present the buffer head if there is one, otherwise bypass a kept response straight through
  always_comb begin
    inst_val  = 1'b0;
    inst_data = c_fetch_reset_inst;
    inst_pc   = p_reset_pc;
    if (!squash) begin
      if (!w_bufEmpty) begin
        inst_val  = 1'b1;
        inst_data = w_bufHead.inst;
        inst_pc   = w_bufHead.pc;
      end else if (w_keep) begin
        inst_val  = 1'b1;
        inst_data = imem_resp_data;
        inst_pc   = w_pcHead;
      end
    end
  end

  // Drain FSM next state: a squash reloads the drop count, DRAIN counts discarded responses down
  always_comb begin
    w_dropNext  = r_dropCnt;
    w_stateNext = r_state;
    if (squash) begin
      w_dropNext = r_inflight - c_cnt_w'(w_respCounted);
    end else if ((r_state == DRAIN) && imem_resp_val) begin
      w_dropNext = r_dropCnt - c_cnt_w'(1);
    end
    w_stateNext = (w_dropNext != '0) ? DRAIN : RUN;
  end

  // Drain FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_dropCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_dropCnt <= w_dropNext;
    end
  end

  // Requests outstanding at imem: up on fire, down on any response, unchanged when both happen
  assign w_inflightNext = r_inflight + c_cnt_w'(w_fire) - c_cnt_w'(w_respCounted);

  // Outstanding request counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= w_inflightNext;
    end
  end

`ifdef LAB2_PROC_FETCH_STATS_EN
  logic [15:0] r_squashDrops;

  // Saturating count of every response thrown away because of a squash
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_squashDrops <= '0;
    end else if (w_drop && (r_squashDrops != 16'hFFFF)) begin
      r_squashDrops <= r_squashDrops + 16'd1;
    end
  end

  assign squash_drops = r_squashDrops;
`else
  logic w_dropUnused;
  assign w_dropUnused = w_drop;
`endif

  // A response with nothing outstanding means the memory side broke the protocol
  a_noOrphanResp : assert property (@(posedge clk) disable iff (!reset) !w_protoErr);

  // Every kept response must find its PC, and the PC FIFO never outgrows the outstanding requests
  a_pcAvailable : assert property (@(posedge clk) disable iff (!reset) !(w_keep && w_pcEmpty));
  a_pcBounded : assert property (@(posedge clk) disable iff (!reset) (w_pcCount <= r_inflight));

endmodule
